// File: rtl/vlc_frame_receiver.sv
// Optical-link receive deserializer: synchronizes rx and detects the high/low preamble,
// then samples 32-bit MSB-first words at bit centres and writes them to the receive FIFO.
module vlc_frame_receiver #(
  parameter int unsigned BIT_CYCLES      = 50,
  parameter int unsigned SYNC_HI_BITS    = 5,
  parameter int unsigned SYNC_LO_BITS    = 5,
  parameter int unsigned WORDS_PER_FRAME = 9,
  parameter int unsigned MIN_GAP_BITS    = 6
) (
  input  logic        pclk,
  input  logic        rstn,
  input  logic        rx,
  input  logic        fifo_full,
  output logic [31:0] dout,
  output logic        fifo_wr_en,
  output logic        frame_done,
  output logic        sync_err,
  output logic        overflow,
  output logic        busy
);

  localparam int unsigned PW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int unsigned WW = $clog2(WORDS_PER_FRAME + 1);

  localparam logic [15:0] TOL     = 16'(BIT_CYCLES / 2);
  localparam logic [15:0] H_NOM   = 16'(SYNC_HI_BITS * BIT_CYCLES);
  localparam logic [15:0] H_MIN   = H_NOM - TOL;
  localparam logic [15:0] H_MAX   = H_NOM + TOL;
  localparam logic [15:0] L_NOM   = 16'(SYNC_LO_BITS * BIT_CYCLES);
  localparam logic [15:0] L_MIN   = L_NOM - TOL;
  localparam logic [15:0] L_END   = L_NOM - 16'd1;
  localparam logic [15:0] GAP_LEN = 16'(MIN_GAP_BITS * BIT_CYCLES);

  localparam logic [PW-1:0] PH_SAMPLE = PW'(BIT_CYCLES / 2);
  localparam logic [PW-1:0] PH_LAST   = PW'(BIT_CYCLES - 1);
  localparam logic [WW-1:0] W_LAST    = WW'(WORDS_PER_FRAME - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC_HI,
    S_SYNC_LO,
    S_DATA,
    S_GAP
  } state_t;

  state_t        state_q;
  logic          rx_meta_q;
  logic          rx_s_q;
  logic          rx_prev_q;
  logic [15:0]   cyc_q;
  logic [PW-1:0] phase_q;
  logic [4:0]    bit_q;
  logic [WW-1:0] wcnt_q;
  logic [31:0]   shift_q;
  logic [31:0]   dout_q;
  logic          wr_en_q;
  logic          frame_done_q;
  logic          sync_err_q;
  logic          overflow_q;

  logic          rise;
  logic          fall;
  logic [15:0]   cyc_d;
  logic [31:0]   shift_d;

  assign rise    = rx_s_q & ~rx_prev_q;
  assign fall    = ~rx_s_q & rx_prev_q;
  assign cyc_d   = cyc_q + 16'd1;
  assign shift_d = {shift_q[30:0], rx_s_q};

  always_ff @(posedge pclk) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      rx_meta_q    <= 1'b0;
      rx_s_q       <= 1'b0;
      rx_prev_q    <= 1'b0;
      cyc_q        <= '0;
      phase_q      <= '0;
      bit_q        <= '0;
      wcnt_q       <= '0;
      shift_q      <= '0;
      dout_q       <= '0;
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      rx_meta_q    <= rx;
      rx_s_q       <= rx_meta_q;
      rx_prev_q    <= rx_s_q;
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      overflow_q   <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (rise) begin
            state_q <= S_SYNC_HI;
            cyc_q   <= '0;
          end
        end

        S_SYNC_HI: begin
          if (fall) begin
            if (cyc_q >= H_MIN && cyc_q <= H_MAX) begin
              state_q <= S_SYNC_LO;
              cyc_q   <= '0;
            end else begin
              sync_err_q <= 1'b1;
              state_q    <= S_IDLE;
            end
          end else if (cyc_q > H_MAX) begin
            sync_err_q <= 1'b1;
            state_q    <= S_IDLE;
          end else begin
            cyc_q <= cyc_d;
          end
        end

        S_SYNC_LO: begin
          // A late rise is the first data bit arriving early; only early rises are rejected.
          if (rise && cyc_q < L_MIN) begin
            sync_err_q <= 1'b1;
            state_q    <= S_IDLE;
          end else if (cyc_q == L_END) begin
            state_q <= S_DATA;
            phase_q <= '0;
            bit_q   <= '0;
            wcnt_q  <= '0;
          end else begin
            cyc_q <= cyc_d;
          end
        end

        S_DATA: begin
          phase_q <= (phase_q == PH_LAST) ? '0 : phase_q + PW'(1);
          if (phase_q == PH_SAMPLE) begin
            shift_q <= shift_d;
            bit_q   <= bit_q + 5'd1;
            if (bit_q == 5'd31) begin
              if (!fifo_full) begin
                dout_q  <= shift_d;
                wr_en_q <= 1'b1;
              end else begin
                overflow_q <= 1'b1;
              end
              wcnt_q <= wcnt_q + WW'(1);
              if (wcnt_q == W_LAST) begin
                frame_done_q <= 1'b1;
                state_q      <= S_GAP;
                cyc_q        <= '0;
              end
            end
          end
        end

        S_GAP: begin
          if (rx_s_q) begin
            cyc_q <= '0;
          end else if (cyc_d == GAP_LEN) begin
            state_q <= S_IDLE;
            cyc_q   <= '0;
          end else begin
            cyc_q <= cyc_d;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dout       = dout_q;
  assign fifo_wr_en = wr_en_q;
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;
  assign overflow   = overflow_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_vlc_frame_receiver.sv
// Directed bench for vlc_frame_receiver: preamble acceptance/rejection, word assembly,
// FIFO-full overflow, mid-frame reset, back-to-back frames and gap glitch handling.
module tb_vlc_frame_receiver;

  // Bit period shortened to keep run time low; all durations are in bit periods.
  localparam int unsigned BC = 20;

  logic        pclk = 1'b0;
  logic        rstn;
  logic        rx;
  logic        fifo_full;
  logic [31:0] dout;
  logic        fifo_wr_en;
  logic        frame_done;
  logic        sync_err;
  logic        overflow;
  logic        busy;

  always #5 pclk = ~pclk;

  vlc_frame_receiver #(
    .BIT_CYCLES     (BC),
    .SYNC_HI_BITS   (5),
    .SYNC_LO_BITS   (5),
    .WORDS_PER_FRAME(9),
    .MIN_GAP_BITS   (6)
  ) dut (
    .pclk      (pclk),
    .rstn      (rstn),
    .rx        (rx),
    .fifo_full (fifo_full),
    .dout      (dout),
    .fifo_wr_en(fifo_wr_en),
    .frame_done(frame_done),
    .sync_err  (sync_err),
    .overflow  (overflow),
    .busy      (busy)
  );

  int unsigned wr_cnt = 0;
  int unsigned fd_cnt = 0;
  int unsigned fd_bad = 0;
  int unsigned se_cnt = 0;
  int unsigned ov_cnt = 0;
  logic [31:0] cap [256];

  always @(negedge pclk) begin
    if (fifo_wr_en === 1'b1) begin
      cap[wr_cnt[7:0]] = dout;
      wr_cnt++;
    end
    if (frame_done === 1'b1) begin
      fd_cnt++;
      if (!(fifo_wr_en === 1'b1 || overflow === 1'b1)) fd_bad++;
    end
    if (sync_err === 1'b1) se_cnt++;
    if (overflow === 1'b1) ov_cnt++;
  end

  int unsigned n_vec = 0;
  int unsigned n_mis = 0;
  logic [31:0] fw [9];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic drive(input logic v, input int unsigned n);
    rx = v;
    repeat (n) @(negedge pclk);
  endtask

  task automatic preamble();
    drive(1'b1, 5 * BC);
    drive(1'b0, 5 * BC);
  endtask

  // Sends fw[] MSB first; stops half-way into (stop_w, stop_b); raises fifo_full during bit 31 of word ff_w.
  task automatic send_words(input int unsigned stop_w, input int unsigned stop_b,
                            input int unsigned ff_w);
    logic [31:0] w_val;
    bit          stopped;
    stopped = 1'b0;
    for (int unsigned w = 0; w < 9 && !stopped; w++) begin
      w_val = fw[w];
      for (int unsigned b = 0; b < 32 && !stopped; b++) begin
        fifo_full = (w == ff_w && b == 31);
        if (w == stop_w && b == stop_b) begin
          drive(w_val[31 - b], BC / 2);
          stopped = 1'b1;
        end else begin
          drive(w_val[31 - b], BC);
        end
      end
    end
    fifo_full = 1'b0;
    rx        = 1'b0;
  endtask

  task automatic load_nominal();
    fw[0] = 32'hDEADBEEF; fw[1] = 32'h12345678; fw[2] = 32'hCAFEF00D;
    fw[3] = 32'h0BADC0DE; fw[4] = 32'h87654321; fw[5] = 32'h13579BDF;
    fw[6] = 32'h2468ACE0; fw[7] = 32'hFEDCBA98; fw[8] = 32'hA5A5A5A5;
  endtask

  int unsigned w0, f0, fb0, s0, o0;

  task automatic snap();
    w0 = wr_cnt; f0 = fd_cnt; fb0 = fd_bad; s0 = se_cnt; o0 = ov_cnt;
  endtask

  initial begin
    rstn      = 1'b0;
    rx        = 1'b0;
    fifo_full = 1'b0;
    idle(4);
    chk("rst_dout", dout, 32'h0);
    chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_sync_err", 32'(sync_err), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rstn = 1'b1;
    idle(10);

    // Nominal frame
    load_nominal();
    snap();
    preamble();
    chk("nom_busy_in_frame", 32'(busy), 32'd1);
    send_words(9, 0, 9);
    idle(8 * BC);
    chk("nom_writes", wr_cnt - w0, 32'd9);
    for (int unsigned i = 0; i < 9; i++) chk("nom_word", cap[8'(w0 + i)], fw[i]);
    chk("nom_frame_done", fd_cnt - f0, 32'd1);
    chk("nom_fd_with_write", fd_bad - fb0, 32'd0);
    chk("nom_sync_err", se_cnt - s0, 32'd0);
    chk("nom_busy_after", 32'(busy), 32'd0);

    // First data bit zero: no edge at data start
    fw[0] = 32'h00000001;
    for (int unsigned i = 1; i < 9; i++) fw[i] = 32'hFFFFFFFF;
    snap();
    preamble();
    send_words(9, 0, 9);
    idle(8 * BC);
    chk("fbz_writes", wr_cnt - w0, 32'd9);
    for (int unsigned i = 0; i < 9; i++) chk("fbz_word", cap[8'(w0 + i)], fw[i]);

    // Short preamble high (3 bits) rejected at the fall
    snap();
    drive(1'b1, 3 * BC);
    drive(1'b0, 10);
    chk("short_sync_err", se_cnt - s0, 32'd1);
    chk("short_busy", 32'(busy), 32'd0);
    drive(1'b0, 6 * BC);
    chk("short_no_write", wr_cnt - w0, 32'd0);

    // Over-long preamble high (6 bits) rejected while still high
    drive(1'b1, 6 * BC);
    chk("long_sync_err", se_cnt - s0, 32'd2);
    chk("long_busy", 32'(busy), 32'd0);
    drive(1'b0, 4 * BC);
    chk("long_no_write", wr_cnt - w0, 32'd0);

    // FIFO full across completion of word 4
    load_nominal();
    snap();
    preamble();
    send_words(9, 0, 3);
    idle(8 * BC);
    chk("ff_writes", wr_cnt - w0, 32'd8);
    chk("ff_overflow", ov_cnt - o0, 32'd1);
    chk("ff_frame_done", fd_cnt - f0, 32'd1);
    chk("ff_fd_aligned", fd_bad - fb0, 32'd0);
    for (int unsigned i = 0; i < 3; i++) chk("ff_word_pre", cap[8'(w0 + i)], fw[i]);
    for (int unsigned i = 4; i < 9; i++) chk("ff_word_post", cap[8'(w0 + i - 1)], fw[i]);
    chk("ff_sync_err", se_cnt - s0, 32'd0);

    // Reset during word 5 bit 17
    snap();
    preamble();
    send_words(4, 17, 9);
    chk("mid_dout_before_rst", dout, 32'h0BADC0DE);
    rx   = 1'b0;
    rstn = 1'b0;
    idle(1);
    chk("mid_rst_dout", dout, 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_wr_en", 32'(fifo_wr_en), 32'd0);
    rstn = 1'b1;
    idle(160 * BC);
    chk("mid_writes", wr_cnt - w0, 32'd4);
    chk("mid_frame_done", fd_cnt - f0, 32'd0);
    chk("mid_busy_idle", 32'(busy), 32'd0);

    // Back-to-back frames separated by 12 bit periods low
    snap();
    preamble();
    send_words(9, 0, 9);
    drive(1'b0, 12 * BC);
    preamble();
    send_words(9, 0, 9);
    idle(8 * BC);
    chk("b2b_writes", wr_cnt - w0, 32'd18);
    for (int unsigned i = 0; i < 18; i++) chk("b2b_word", cap[8'(w0 + i)], fw[i % 9]);
    chk("b2b_frame_done", fd_cnt - f0, 32'd2);
    chk("b2b_fd_aligned", fd_bad - fb0, 32'd0);

    // Glitch in the gap restarts it; a preamble 4 bits later is ignored
    snap();
    preamble();
    send_words(9, 0, 9);
    drive(1'b0, 2 * BC);
    drive(1'b1, 10);
    drive(1'b0, 4 * BC);
    chk("gap_still_busy", 32'(busy), 32'd1);
    preamble();
    idle(10 * BC);
    chk("gap_writes", wr_cnt - w0, 32'd9);
    chk("gap_frame_done", fd_cnt - f0, 32'd1);
    chk("gap_sync_err", se_cnt - s0, 32'd0);
    chk("gap_busy_end", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
